// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative signed/unsigned multiply and divide for EX.
// One shift-add / restoring-divide datapath behind a start/ready handshake.
module muldiv_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [1:0]         op_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               annul_i,
  output logic               busy_o,
  output logic               stallreq_o,
  output logic               ready_o,
  output logic               div_zero_o,
  output logic [2*WIDTH-1:0] result_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_e;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               div_q;
  logic               neg_q;
  logic               rneg_q;
  logic [WIDTH-1:0]   m_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] res_q;
  logic               busy_q;
  logic               ready_q;
  logic               dz_q;

  logic               sgn1;
  logic               sgn2;
  logic               accept;
  logic               dz_hit;
  logic [WIDTH-1:0]   mag1;
  logic [WIDTH-1:0]   mag2;
  logic [WIDTH:0]     add_w;
  logic [WIDTH:0]     shl_w;
  logic [WIDTH-1:0]   sub_w;
  logic               ge;
  logic [WIDTH-1:0]   q_fix;
  logic [WIDTH-1:0]   r_fix;
  logic [2*WIDTH-1:0] mul_d;
  logic [2*WIDTH-1:0] div_d;
  logic [2*WIDTH-1:0] acc_d;
  logic [2*WIDTH-1:0] fix_d;

  // Operand conditioning: magnitudes and sign flags for signed ops.
  always_comb begin
    sgn1   = ~op_i[0] & opdata1_i[WIDTH-1];
    sgn2   = ~op_i[0] & opdata2_i[WIDTH-1];
    mag1   = sgn1 ? -opdata1_i : opdata1_i;
    mag2   = sgn2 ? -opdata2_i : opdata2_i;
    accept = start_i & ~annul_i & (state_q == S_IDLE);
    dz_hit = op_i[1] & (opdata2_i == '0);
  end

  // One iteration step plus the sign fix-up of the finished result.
  always_comb begin
    add_w = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
          + (acc_q[0] ? {1'b0, m_q} : '0);
    mul_d = {add_w, acc_q[WIDTH-1:1]};
    shl_w = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    ge    = shl_w >= {1'b0, m_q};
    sub_w = shl_w[WIDTH-1:0] - m_q;
    div_d = ge ? {sub_w, acc_q[WIDTH-2:0], 1'b1}
               : {shl_w[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    acc_d = div_q ? div_d : mul_d;
    q_fix = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    r_fix = rneg_q ? -acc_q[2*WIDTH-1:WIDTH]
                   : acc_q[2*WIDTH-1:WIDTH];
    fix_d = div_q ? {r_fix, q_fix} : (neg_q ? -acc_q : acc_q);
  end

  // Control FSM with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      m_q     <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      dz_q    <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            cnt_q  <= '0;
            div_q  <= op_i[1];
            neg_q  <= sgn1 ^ sgn2;
            rneg_q <= sgn1 & op_i[1];
            if (op_i[1]) begin
              acc_q <= {{WIDTH{1'b0}}, mag1};
              m_q   <= mag2;
            end else begin
              acc_q <= {{WIDTH{1'b0}}, mag2};
              m_q   <= mag1;
            end
            if (dz_hit) begin
              state_q <= S_DONE;
              ready_q <= 1'b1;
              dz_q    <= 1'b1;
              res_q   <= {opdata1_i, {WIDTH{1'b1}}};
            end else begin
              state_q <= S_CALC;
              busy_q  <= 1'b1;
            end
          end
        end
        S_CALC: begin
          if (annul_i) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST) state_q <= S_FIX;
          end
        end
        S_FIX: begin
          busy_q <= 1'b0;
          if (annul_i) begin
            state_q <= S_IDLE;
          end else begin
            res_q   <= fix_d;
            state_q <= S_DONE;
            ready_q <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign stallreq_o = accept | busy_q;
  assign ready_o    = ready_q;
  assign div_zero_o = dz_q;
  assign result_o   = res_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// tb_muldiv_iter: scoreboard bench for muldiv_iter at WIDTH 32 and 8.
// Random and directed ops checked against an arithmetic reference model.
module tb_muldiv_iter;

  typedef struct {
    logic [63:0] res;
    bit          dz;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        st32, an32, busy32, stall32, rdy32, dz32;
  logic [1:0]  op32;
  logic [31:0] a32, b32;
  logic [63:0] res32;
  logic        st8, an8, busy8, stall8, rdy8, dz8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8;
  logic [15:0] res8;

  muldiv_iter #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start_i(st32), .op_i(op32),
    .opdata1_i(a32), .opdata2_i(b32), .annul_i(an32),
    .busy_o(busy32), .stallreq_o(stall32), .ready_o(rdy32),
    .div_zero_o(dz32), .result_o(res32)
  );

  muldiv_iter #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start_i(st8), .op_i(op8),
    .opdata1_i(a8), .opdata2_i(b8), .annul_i(an8),
    .busy_o(busy8), .stallreq_o(stall8), .ready_o(rdy8),
    .div_zero_o(dz8), .result_o(res8)
  );

  int   tests = 0;
  int   fails = 0;
  exp_t q32[$];
  exp_t q8[$];
  exp_t m32, m8;

  // Reference: plain integer arithmetic on sign-extended values.
  function automatic logic [63:0] ref_md(int w, logic [1:0] op,
      logic [31:0] a, logic [31:0] b, output bit dz);
    longint sa, sb, mw, pm, q, r;
    mw = (longint'(1) << w) - 1;
    pm = (w >= 32) ? -1 : ((longint'(1) << (2 * w)) - 1);
    sa = longint'(a);
    sb = longint'(b);
    if (!op[0]) begin
      if (a[w-1]) sa = sa - (longint'(1) << w);
      if (b[w-1]) sb = sb - (longint'(1) << w);
    end
    dz = 1'b0;
    if (!op[1]) return 64'((sa * sb) & pm);
    if (sb == 0) begin
      dz = 1'b1;
      return 64'(((sa & mw) << w) | mw);
    end
    q = sa / sb;
    r = sa % sb;
    return 64'(((r & mw) << w) | (q & mw));
  endfunction

  function automatic logic [31:0] pick(int w);
    logic [31:0] v, mk;
    mk = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    case ($urandom_range(0, 7))
      0: v = 32'h0;
      1: v = 32'h1;
      2: v = 32'hFFFF_FFFF;
      3: v = (w == 32) ? 32'h8000_0000 : 32'h80;
      default: v = $urandom;
    endcase
    return v & mk;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic go(bit w8, logic [1:0] op, logic [31:0] a,
                    logic [31:0] b, bit push);
    exp_t e;
    bit   dz;
    e.res = ref_md(w8 ? 8 : 32, op, a, b, dz);
    e.dz  = dz;
    if (w8) begin
      st8 = 1'b1; op8 = op; a8 = a[7:0]; b8 = b[7:0];
    end else begin
      st32 = 1'b1; op32 = op; a32 = a; b32 = b;
    end
    if (push) begin
      if (w8) q8.push_back(e);
      else q32.push_back(e);
    end
    @(posedge clk);
    #1;
    st8  = 1'b0;
    st32 = 1'b0;
  endtask

  task automatic wait_rdy(bit w8, int n0, output int n, output int bc);
    bit seen;
    seen = 1'b0;
    n  = n0;
    bc = 0;
    while (!seen && n < 200) begin
      @(negedge clk);
      if (w8 ? busy8 : busy32) bc++;
      if (w8 ? rdy8 : rdy32) seen = 1'b1;
      else begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(bit w8, logic [1:0] op, logic [31:0] a,
                     logic [31:0] b, string nm);
    int w, lat, bc, want;
    w = w8 ? 8 : 32;
    go(w8, op, a, b, 1'b1);
    wait_rdy(w8, 1, lat, bc);
    want = (op[1] && b == 0) ? 1 : w + 2;
    chk({nm, "_lat"}, 64'(lat), 64'(want));
    chk({nm, "_busy"}, 64'(bc), 64'((want == 1) ? 0 : w + 1));
  endtask

  // Scoreboard monitors: pop and compare on every ready pulse.
  always @(negedge clk) begin
    if (!rst && rdy32) begin
      tests++;
      if (q32.size() == 0) begin
        fails++;
        $display("FAIL mon32_unexpected: ready with no request, res %h",
                 res32);
      end else begin
        m32 = q32.pop_front();
        if (res32 !== m32.res || dz32 !== m32.dz) begin
          fails++;
          $display("FAIL mon32: got %h dz %b want %h dz %b",
                   res32, dz32, m32.res, m32.dz);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && rdy8) begin
      tests++;
      if (q8.size() == 0) begin
        fails++;
        $display("FAIL mon8_unexpected: ready with no request, res %h",
                 res8);
      end else begin
        m8 = q8.pop_front();
        if (res8 !== m8.res[15:0] || dz8 !== m8.dz) begin
          fails++;
          $display("FAIL mon8: got %h dz %b want %h dz %b",
                   res8, dz8, m8.res[15:0], m8.dz);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    logic [63:0] save;
    int          lat, bc, cnt;
    logic        r2;
    exp_t        e;
    bit          dz;

    rst = 1'b1;
    st32 = 0; an32 = 0; op32 = 0; a32 = 0; b32 = 0;
    st8 = 0; an8 = 0; op8 = 0; a8 = 0; b8 = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst32_res", res32, 64'h0);
    chk("rst32_flags", 64'({busy32, rdy32, dz32, stall32}), 64'h0);
    chk("rst8_all", 64'({busy8, rdy8, dz8, stall8, res8}), 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // start with annul in IDLE: no stall, not accepted
    st32 = 1'b1; an32 = 1'b1; op32 = 2'b01; a32 = 3; b32 = 5;
    @(negedge clk);
    chk("idle_annul_stall", 64'(stall32), 64'h0);
    @(posedge clk);
    #1;
    an32 = 1'b0;
    @(negedge clk);
    chk("idle_annul_noaccept", 64'(busy32), 64'h0);
    chk("idle_start_stall", 64'(stall32), 64'h1);
    st32 = 1'b0;
    @(posedge clk);
    #1;

    // directed vectors
    run(0, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "umul_max");
    chk("umul_max_res", res32, 64'hFFFF_FFFE_0000_0001);
    run(0, 2'b00, 32'hFFFF_FFFD, 32'h0000_0005, "smul_neg");
    chk("smul_neg_res", res32, 64'hFFFF_FFFF_FFFF_FFF1);
    run(0, 2'b00, 32'h8000_0000, 32'h8000_0000, "smul_min");
    chk("smul_min_res", res32, 64'h4000_0000_0000_0000);
    run(0, 2'b10, 32'hFFFF_FFF9, 32'h0000_0002, "sdiv_neg");
    chk("sdiv_neg_res", res32, 64'hFFFF_FFFF_FFFF_FFFD);
    run(0, 2'b11, 32'd100, 32'd7, "udiv");
    chk("udiv_res", res32, 64'h0000_0002_0000_000E);
    run(0, 2'b11, 32'd100, 32'd0, "udiv_zero");
    chk("udiv_zero_res", res32, 64'h0000_0064_FFFF_FFFF);
    run(0, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "sdiv_ovf");
    chk("sdiv_ovf_res", res32, 64'h0000_0000_8000_0000);
    run(1, 2'b00, 32'h80, 32'hFF, "w8_smul");
    chk("w8_smul_res", 64'(res8), 64'h0080);
    run(1, 2'b10, 32'h81, 32'h03, "w8_sdiv");
    chk("w8_sdiv_res", 64'(res8), 64'hFFD6);

    // random traffic on both widths
    for (int i = 0; i < 30; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = pick(32);
      rb  = pick(32);
      run(0, rop, ra, rb, "rnd32");
    end
    for (int i = 0; i < 30; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = pick(8);
      rb  = pick(8);
      run(1, rop, ra, rb, "rnd8");
    end

    // annul mid-CALC: no ready, result kept
    save = res32;
    go(0, 2'b10, 32'h1234_5678, 32'h0000_0003, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    an32 = 1'b1;
    @(posedge clk);
    #1;
    an32 = 1'b0;
    @(negedge clk);
    chk("annul_busy", 64'(busy32), 64'h0);
    chk("annul_res", res32, save);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rdy32) cnt++;
    end
    chk("annul_noready", 64'(cnt), 64'h0);
    @(posedge clk);
    #1;

    // start during CALC is ignored
    go(0, 2'b11, 32'd1000, 32'd7, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    st32 = 1'b1; op32 = 2'b00; a32 = 32'hDEAD_BEEF; b32 = 32'h55;
    @(posedge clk);
    #1;
    st32 = 1'b0;
    wait_rdy(0, 6, lat, bc);
    chk("busy_start_lat", 64'(lat), 64'd34);
    chk("busy_start_res", res32, 64'h0000_0006_0000_008E);

    // start held through DONE: accepted only every other cycle
    e.res = ref_md(32, 2'b11, 32'd100, 32'd0, dz);
    e.dz  = dz;
    repeat (3) q32.push_back(e);
    st32 = 1'b1; op32 = 2'b11; a32 = 32'd100; b32 = 32'd0;
    @(posedge clk);
    #1;
    cnt = 0;
    r2  = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      if (rdy32) cnt++;
      if (i == 2) r2 = rdy32;
      @(posedge clk);
      #1;
      if (i == 4) st32 = 1'b0;
    end
    chk("done_start_count", 64'(cnt), 64'd3);
    chk("done_start_ignored", 64'(r2), 64'h0);

    // synchronous reset in the middle of an operation
    go(0, 2'b00, 32'h0000_1234, 32'h0000_0567, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    q32.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_res", res32, 64'h0);
    chk("midrst_flags", 64'({busy32, rdy32, dz32, stall32}), 64'h0);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rdy32) cnt++;
    end
    chk("midrst_noready", 64'(cnt), 64'h0);
    @(posedge clk);
    #1;
    run(0, 2'b01, 32'd6, 32'd7, "after_rst");
    chk("after_rst_res", res32, 64'd42);

    chk("queue32_drained", 64'(q32.size()), 64'h0);
    chk("queue8_drained", 64'(q8.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
